mips_output_display: RTL and testbench

Sequential output stage that consumes the processor's `output_flag` strobe and the 32-bit register value it qualifies (`read_data1`). It converts that value to signed decimal with an iterative double-dabble engine and drives active-low 7-segment digits. It replaces the combinational `bcd` decode at the processor's output side and holds the displayed value until the next accepted output. Display data is registered, so HEX outputs never glitch during a conversion.

---
 rtl/mips_output_display_if.sv | 24 ++
 rtl/mips_output_display.sv | 188 ++++++++++++++++++
 tb/tb_mips_output_display.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_output_display_if.sv
// Bundle of the output strobe/value coming from the processor and the
// display-side results. The producer (processor or bench) uses master,
// the display stage uses slave.
interface mips_output_display_if #(
    parameter int DIGITS = 3
);
    logic                  out_valid;
    logic [31:0]           out_data;
    logic [7*DIGITS-1:0]   hex_out;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic                  overrun;

    modport master (
        output out_valid, out_data,
        input  hex_out, busy, done, overflow, overrun
    );

    modport slave (
        input  out_valid, out_data,
        output hex_out, busy, done, overflow, overrun
    );
endinterface

// File: rtl/mips_output_display.sv
// Processor output stage: edge-detects the output strobe, converts the
// qualified 32-bit two's-complement value to signed decimal with a
// one-bit-per-cycle double-dabble engine and holds active-low 7-segment
// patterns until the next conversion completes. One value may wait in a
// single-entry buffer while a conversion runs; a newer one replaces it.
module mips_output_display #(
    parameter int DIGITS = 3
) (
    input  logic               clock,
    input  logic               reset,
    mips_output_display_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ABS   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    // Digit 0 shows "0", every other digit blank.
    localparam logic [7*DIGITS-1:0] HEX_RESET = {{(7*(DIGITS-1)){1'b1}}, 7'b1000000};

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    state_t              r_state;
    state_t              w_state_next;
    logic                r_valid_prev;
    logic                w_accept;
    logic [31:0]         r_data;
    logic [31:0]         r_pend;
    logic                r_pend_valid;
    logic                r_sign;
    logic [31:0]         r_mag;
    logic [31:0]         w_mag;
    logic [39:0]         r_bcd;
    logic [35:0]         w_bcd_adj;
    logic [5:0]          r_cnt;
    logic [7*DIGITS-1:0] r_hex;
    logic [7*DIGITS-1:0] w_hex_comp;
    logic                r_done;
    logic                r_overflow;
    logic                r_overrun;
    logic                w_ovf;
    logic [3:0]          w_msd;

    assign w_accept = bus.out_valid & ~r_valid_prev;

    // Unsigned two's-complement magnitude; 0x80000000 maps to 2^31.
    assign w_mag = r_data[31] ? (~r_data + 32'd1) : r_data;

    // Add-3 correction on the lower nine nibbles. The top nibble never
    // exceeds 4 for a 32-bit magnitude, so it needs no correction.
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_adj
            assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                          (r_bcd[4*gi +: 4] + 4'd3) : r_bcd[4*gi +: 4];
        end
    endgenerate

    // Overflow test and position of the most significant nonzero digit.
    always_comb begin
        w_ovf = 1'b0;
        w_msd = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (r_bcd[4*k +: 4] != 4'd0) begin
                w_msd = 4'(k);
                if (k >= DIGITS || (r_sign && k >= DIGITS - 1)) begin
                    w_ovf = 1'b1;
                end
            end
        end
    end

    // Per-digit pattern: minus on overflow or in the sign position,
    // leading zeros blanked except digit 0.
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_hex_comp[7*gi +: 7] =
                w_ovf                               ? SEG_MINUS :
                (r_sign && (gi == DIGITS - 1))      ? SEG_MINUS :
                ((gi == 0) || (4'(gi) <= w_msd))    ? f_seg(r_bcd[4*gi +: 4]) :
                                                      SEG_BLANK;
        end
    endgenerate

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_ABS;
            S_ABS:   w_state_next = S_SHIFT;
            S_SHIFT: if (r_cnt == 6'd31) w_state_next = S_DONE;
            S_DONE:  w_state_next = (w_accept || r_pend_valid) ? S_ABS : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: capture, conversion, pending buffer and display registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid_prev <= 1'b0;
            r_data       <= 32'd0;
            r_pend       <= 32'd0;
            r_pend_valid <= 1'b0;
            r_sign       <= 1'b0;
            r_mag        <= 32'd0;
            r_bcd        <= 40'd0;
            r_cnt        <= 6'd0;
            r_hex        <= HEX_RESET;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_valid_prev <= bus.out_valid;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) r_data <= bus.out_data;
                end
                S_ABS: begin
                    r_sign <= r_data[31];
                    r_mag  <= w_mag;
                    r_bcd  <= 40'd0;
                    r_cnt  <= 6'd0;
                end
                S_SHIFT: begin
                    r_bcd <= {r_bcd[38:36], w_bcd_adj, r_mag[31]};
                    r_mag <= {r_mag[30:0], 1'b0};
                    r_cnt <= r_cnt + 6'd1;
                end
                S_DONE: begin
                    r_hex      <= w_hex_comp;
                    r_overflow <= w_ovf;
                    r_done     <= 1'b1;
                    // A fresh strobe outranks the buffered value.
                    if (w_accept) begin
                        r_data <= bus.out_data;
                    end else if (r_pend_valid) begin
                        r_data       <= r_pend;
                        r_pend_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
            // Strobes arriving mid-conversion go to the one-entry buffer.
            if (w_accept && (r_state == S_ABS || r_state == S_SHIFT)) begin
                r_pend       <= bus.out_data;
                r_pend_valid <= 1'b1;
                if (r_pend_valid) r_overrun <= 1'b1;
            end
        end
    end

    assign bus.hex_out  = r_hex;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = r_done;
    assign bus.overflow = r_overflow;
    assign bus.overrun  = r_overrun;
endmodule

// File: tb/tb_mips_output_display.sv
// Bench for the 7-segment output stage. A timing-level model (conversion
// occupies 34 edges, one waiting slot) predicts which value each done pulse
// must show; the expected display is computed with plain decimal arithmetic.
module tb_mips_output_display;
    localparam int N = 3;
    localparam logic [6:0] MINUS = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic clk;
    logic reset;

    mips_output_display_if #(.DIGITS(N)) bus_if ();

    mips_output_display #(.DIGITS(N)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        int          done_cyc;
    } exp_t;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [6:0]  seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Model state.
    logic        m_active = 1'b0;
    int          m_done_edge = 0;
    logic        m_pend = 1'b0;
    logic [31:0] m_pend_val = 32'd0;
    logic        m_prev = 1'b0;
    logic        m_ovr = 1'b0;

    // Monitor state.
    logic [7*N-1:0] shown_hex;
    logic           shown_ovf;

    function automatic logic [7*N-1:0] reset_pattern();
        logic [7*N-1:0] h;
        for (int k = 0; k < N; k++) h[7*k +: 7] = BLANK;
        h[6:0] = seg_tab[0];
        return h;
    endfunction

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endfunction

    // Signed-decimal display of v from the display rules.
    function automatic void f_expect(input logic [31:0] v, output logic [7*N-1:0] h, output logic o);
        longint mag;
        longint lim;
        longint rem;
        logic   neg;
        neg = v[31];
        mag = neg ? (64'h1_0000_0000 - longint'({32'd0, v})) : longint'({32'd0, v});
        lim = 1;
        for (int k = 0; k < (neg ? N - 1 : N); k++) lim = lim * 10;
        if (mag >= lim) begin
            o = 1'b1;
            for (int k = 0; k < N; k++) h[7*k +: 7] = MINUS;
        end else begin
            o = 1'b0;
            rem = mag;
            for (int k = 0; k < N; k++) begin
                h[7*k +: 7] = (k == 0 || rem != 0) ? seg_tab[int'(rem % 10)] : BLANK;
                rem = rem / 10;
            end
            if (neg) h[7*(N-1) +: 7] = MINUS;
        end
    endfunction

    function automatic void m_start(input logic [31:0] v, input int e);
        exp_t x;
        m_active    = 1'b1;
        m_done_edge = e + 34;
        x.val       = v;
        x.done_cyc  = e + 34;
        q.push_back(x);
    endfunction

    // Reference model: observes the driven inputs at each rising edge.
    always @(posedge clk) begin
        logic acc;
        cyc++;
        m_ovr = 1'b0;
        if (reset) begin
            m_active = 1'b0;
            m_pend   = 1'b0;
            m_prev   = 1'b0;
            q.delete();
        end else begin
            acc    = bus_if.out_valid && !m_prev;
            m_prev = bus_if.out_valid;
            if (m_active && cyc == m_done_edge) begin
                if (acc) begin
                    m_start(bus_if.out_data, cyc);
                end else if (m_pend) begin
                    m_start(m_pend_val, cyc);
                    m_pend = 1'b0;
                end else begin
                    m_active = 1'b0;
                end
            end else if (m_active) begin
                if (acc) begin
                    if (m_pend) m_ovr = 1'b1;
                    m_pend     = 1'b1;
                    m_pend_val = bus_if.out_data;
                end
            end else if (acc) begin
                m_start(bus_if.out_data, cyc);
            end
        end
    end

    // Monitor: pops the scoreboard on each done and checks steady outputs.
    always @(negedge clk) begin
        exp_t           e;
        logic [7*N-1:0] h;
        logic           o;
        if (reset) begin
            shown_hex = reset_pattern();
            shown_ovf = 1'b0;
            chk("reset_done", 64'(bus_if.done), 64'd0);
        end else if (bus_if.done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 64'(bus_if.done), 64'd0);
            end else begin
                e = q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
                f_expect(e.val, h, o);
                shown_hex = h;
                shown_ovf = o;
                $display("done cyc=%0d val=%0d hex=%b ovf=%b", cyc, $signed(e.val), bus_if.hex_out, bus_if.overflow);
            end
        end else if (q.size() > 0 && q[0].done_cyc <= cyc) begin
            e = q.pop_front();
            chk("missing_done", 64'(bus_if.done), 64'd1);
        end
        chk("hex_out", 64'(bus_if.hex_out), 64'(shown_hex));
        chk("overflow", 64'(bus_if.overflow), 64'(shown_ovf));
        chk("busy", 64'(bus_if.busy), 64'(m_active));
        chk("overrun", 64'(bus_if.overrun), 64'(m_ovr));
    end

    task automatic pulse(input logic [31:0] v, input int hold);
        @(negedge clk); #1;
        bus_if.out_valid = 1'b1;
        bus_if.out_data  = v;
        repeat (hold) @(negedge clk);
        #1;
        bus_if.out_valid = 1'b0;
        bus_if.out_data  = $urandom;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 400 && (m_active || m_pend); i++) @(negedge clk);
        if (m_active || m_pend) chk("idle_timeout", 64'd1, 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [31:0] bnd [7];
        logic [31:0] v;
        bnd[0] = 32'd999;  bnd[1] = 32'd1000; bnd[2] = -32'sd99; bnd[3] = -32'sd100;
        bnd[4] = 32'd0;    bnd[5] = 32'h8000_0000; bnd[6] = 32'h7FFF_FFFF;

        reset            = 1'b1;
        bus_if.out_valid = 1'b0;
        bus_if.out_data  = 32'd0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;

        pulse(32'd123, 1);           wait_idle();
        pulse(32'd0, 1);             wait_idle();
        pulse(32'hFFFF_FFD3, 1);     wait_idle();
        pulse(32'd1000, 1);          wait_idle();
        pulse(-32'sd100, 1);         wait_idle();
        pulse(32'h8000_0000, 1);     wait_idle();
        pulse(32'd7, 1);             wait_idle();

        // Long level: accepted once; later data changes are ignored.
        @(negedge clk); #1;
        bus_if.out_valid = 1'b1;
        bus_if.out_data  = 32'd5;
        repeat (10) @(negedge clk);
        #1 bus_if.out_data = 32'd77;
        repeat (190) @(negedge clk);
        #1 bus_if.out_valid = 1'b0;
        wait_idle();

        // Overwrite of the waiting value.
        pulse(32'd1, 1);
        repeat (5) @(negedge clk);
        pulse(32'd2, 1);
        pulse(32'd3, 1);
        wait_idle();

        // Reset in the middle of a conversion, then a normal one.
        pulse(32'd999, 1);
        repeat (19) @(negedge clk);
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        pulse(32'd999, 1);           wait_idle();

        // Randomized strobes, including arrivals on the DONE edge.
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk); #1;
            if (bus_if.out_valid) begin
                if ($urandom_range(0, 1) == 0) bus_if.out_valid = 1'b0;
                else if ($urandom_range(0, 3) == 0) bus_if.out_data = $urandom;
            end else if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 4))
                    0: v = 32'($urandom_range(0, 999));
                    1: v = 32'd0 - 32'($urandom_range(0, 99));
                    2: v = $urandom;
                    3: v = bnd[$urandom_range(0, 6)];
                    default: v = 32'($urandom_range(0, 50));
                endcase
                bus_if.out_valid = 1'b1;
                bus_if.out_data  = v;
            end
        end
        #1 bus_if.out_valid = 1'b0;
        wait_idle();
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
